// File: rtl/seg_scan_capture.sv
// seg_scan_capture: watches a scanned, active-low 7-segment seg/an bus and
// rebuilds complete 4-digit BCD frames. A dwell only counts once {an,seg} has
// held still long enough, which rejects transition glitches.
// A frame is published when a slot repeats (scan wrap) or when the bus has
// been idle too long.
module seg_scan_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] blank_mask,
  output logic       frame_strobe,
  output logic [2:0] frame_flags,
  output logic       seg_error,
  output logic       an_error
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES - 1);

  logic [10:0]   sample_q;
  logic [SW-1:0] stab_cnt;
  logic          dwell_acc;
  logic [IW-1:0] idle_cnt;
  logic [3:0]    seen;
  logic [3:0]    wblank;
  logic [2:0]    wflags;
  logic [3:0]    wval [4];

  logic       same;
  logic       qual;
  logic [3:0] q_an;
  logic [6:0] q_seg;
  logic [3:0] dec_val;
  logic       dec_blank;
  logic       dec_err;
  logic       slot_hit;
  logic [1:0] slot_idx;
  logic       multi_low;
  logic       accept;
  logic       an_bad;
  logic       wrap;
  logic       timeout;
  logic [3:0] pub_d [4];

  // The registered sample is the pattern being qualified. It is decoded
  // rather than the live input, because the live input may already have
  // moved on to the next slot.
  assign same    = ({an, seg} == sample_q);
  assign qual    = (stab_cnt == STAB_MAX) && !dwell_acc;
  assign q_an    = sample_q[10:7];
  assign q_seg   = sample_q[6:0];
  assign accept  = qual && slot_hit;
  assign an_bad  = qual && multi_low;
  assign wrap    = accept && seen[slot_idx];
  assign timeout = !accept && (idle_cnt == IDLE_MAX);

  // Map a segment pattern back to BCD.
  // The all-off pattern is a legal blank; any other unknown pattern is an error.
  always_comb begin
    dec_val   = 4'hF;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (q_seg)
      7'b1000000: dec_val = 4'd0;
      7'b1111001: dec_val = 4'd1;
      7'b0100100: dec_val = 4'd2;
      7'b0110000: dec_val = 4'd3;
      7'b0011001: dec_val = 4'd4;
      7'b0010010: dec_val = 4'd5;
      7'b0000010: dec_val = 4'd6;
      7'b1111000: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0010000: dec_val = 4'd9;
      7'b1111111: dec_blank = 1'b1;
      default: begin
        dec_blank = 1'b1;
        dec_err   = 1'b1;
      end
    endcase
  end

  // Classify the anode pattern: exactly one low bit selects a slot;
  // several low bits is an anode fault; all high means dark.
  always_comb begin
    slot_hit = 1'b0;
    slot_idx = 2'd0;
    case (~q_an)
      4'b0001: begin slot_hit = 1'b1; slot_idx = 2'd0; end
      4'b0010: begin slot_hit = 1'b1; slot_idx = 2'd1; end
      4'b0100: begin slot_hit = 1'b1; slot_idx = 2'd2; end
      4'b1000: begin slot_hit = 1'b1; slot_idx = 2'd3; end
      default: ;
    endcase
    multi_low = (q_an != 4'b1111) && !slot_hit;
  end

  // Frame contents as they would be published now; unseen slots read as blank.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pub_d[i] = seen[i] ? wval[i] : 4'hF;
    end
  end

  // Stability filter, frame assembly and publishing in one sequential block.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q     <= {4'b1111, 7'b1111111};
      stab_cnt     <= '0;
      dwell_acc    <= 1'b0;
      idle_cnt     <= '0;
      seen         <= 4'b0000;
      wblank       <= 4'b0000;
      wflags       <= 3'b000;
      for (int i = 0; i < 4; i++) wval[i] <= 4'hF;
      digit0       <= 4'hF;
      digit1       <= 4'hF;
      digit2       <= 4'hF;
      digit3       <= 4'hF;
      blank_mask   <= 4'b1111;
      frame_flags  <= 3'b000;
      frame_strobe <= 1'b0;
      seg_error    <= 1'b0;
      an_error     <= 1'b0;
    end else begin
      sample_q <= {an, seg};
      if (!same) begin
        stab_cnt  <= '0;
        dwell_acc <= 1'b0;
      end else begin
        if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + SW'(1);
        if (qual) dwell_acc <= 1'b1;
      end

      frame_strobe <= 1'b0;
      seg_error    <= accept && dec_err;
      an_error     <= an_bad;

      if (accept) begin
        idle_cnt       <= '0;
        wval[slot_idx] <= dec_val;
        if (wrap) begin
          digit0       <= pub_d[0];
          digit1       <= pub_d[1];
          digit2       <= pub_d[2];
          digit3       <= pub_d[3];
          blank_mask   <= ~seen | wblank;
          frame_flags  <= wflags;
          frame_strobe <= 1'b1;
          seen         <= 4'b0001 << slot_idx;
          wblank       <= {3'b000, dec_blank} << slot_idx;
          wflags       <= {2'b00, dec_err};
        end else begin
          seen[slot_idx]   <= 1'b1;
          wblank[slot_idx] <= dec_blank;
          wflags[0]        <= wflags[0] | dec_err;
        end
      end else if (timeout) begin
        digit0       <= pub_d[0];
        digit1       <= pub_d[1];
        digit2       <= pub_d[2];
        digit3       <= pub_d[3];
        blank_mask   <= ~seen | wblank;
        frame_flags  <= {1'b1, wflags[1:0]};
        frame_strobe <= 1'b1;
        seen         <= 4'b0000;
        wblank       <= 4'b0000;
        wflags       <= {1'b0, an_bad, 1'b0};
        idle_cnt     <= '0;
      end else begin
        idle_cnt <= idle_cnt + IW'(1);
        if (an_bad) wflags[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed, table-driven bench for seg_scan_capture,
// with hand-written sequences for latency, glitch, errors, timeout and reset.
module tb_seg_scan_capture;

  localparam int SC    = 4;
  localparam int TC    = 64;
  localparam int DWELL = 10;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] BAD1 = 7'b1010101;
  localparam logic [6:0] BAD2 = 7'b0101010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an = 4'hF;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic [3:0] blank_mask;
  logic       frame_strobe;
  logic [2:0] frame_flags;
  logic       seg_error, an_error;

  seg_scan_capture #(.STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blank_mask(blank_mask), .frame_strobe(frame_strobe),
    .frame_flags(frame_flags), .seg_error(seg_error), .an_error(an_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int seg_pulses = 0;
  int an_pulses = 0;
  logic [15:0] cap_d;
  logic [3:0]  cap_b;
  logic [2:0]  cap_f;

  // Count output pulses and latch each published frame, sampled 2 time units after the clock edge.
  always @(posedge clk) begin
    #2;
    if (frame_strobe) begin
      strobes++;
      cap_d = {digit3, digit2, digit1, digit0};
      cap_b = blank_mask;
      cap_f = frame_flags;
    end
    if (seg_error) seg_pulses++;
    if (an_error) an_pulses++;
  end

  typedef struct {
    logic [15:0] an_v;
    logic [27:0] seg_v;
    logic [15:0] exp_d;
    logic [3:0]  exp_b;
    logic [2:0]  exp_f;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int cycles);
    an  = a;
    seg = s;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'h7F;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input logic [15:0] d, input logic [3:0] b, input logic [2:0] f);
    checkOutput({tag, " digits"}, cap_d, d);
    checkOutput({tag, " blank_mask"}, {12'h0, cap_b}, {12'h0, b});
    checkOutput({tag, " flags"}, {13'h0, cap_f}, {13'h0, f});
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, sp, ap, n, m;
    logic [15:0] av;
    logic [27:0] sv;

    vecs[0] = '{16'h7BDE, {P1, P2, P3, P4}, 16'h1234, 4'b0000, 3'b000};
    vecs[1] = '{16'h7BFF, {P1, P2, PB, PB}, 16'h12FF, 4'b0011, 3'b000};
    vecs[2] = '{16'h7BDE, {P7, P6, P5, P0}, 16'h7650, 4'b0000, 3'b000};
    vecs[3] = '{16'h7BDE, {PB, P1, P9, P8}, 16'hF198, 4'b1000, 3'b000};
    vecs[4] = '{16'h7BDE, {P2, P4, BAD1, P3}, 16'h24F3, 4'b0010, 3'b001};

    @(negedge clk);
    doReset();
    checkOutput("reset digits", {digit3, digit2, digit1, digit0}, 16'hFFFF);
    checkOutput("reset blank_mask", {12'h0, blank_mask}, 16'h000F);
    checkOutput("reset flags/pulses", {12'h0, frame_flags, frame_strobe, seg_error, an_error}, 16'h0);

    // Two full scan rounds per record; the wrap publishes the first round.
    for (int r = 0; r < 5; r++) begin
      doReset();
      base = strobes;
      av = vecs[r].an_v;
      sv = vecs[r].seg_v;
      for (int rnd = 0; rnd < 2; rnd++)
        for (int i = 0; i < 4; i++)
          applyStimulus(av[i*4 +: 4], sv[i*7 +: 7], DWELL);
      checkOutput($sformatf("vec%0d strobe count", r), 16'(strobes - base), 16'd1);
      checkFrame($sformatf("vec%0d", r), vecs[r].exp_d, vecs[r].exp_b, vecs[r].exp_f);
    end

    // Strobe latency: STABLE_CYCLES edges after the wrapping slot is first sampled.
    doReset();
    applyStimulus(4'hE, P4, DWELL);
    applyStimulus(4'hD, P3, DWELL);
    applyStimulus(4'hB, P2, DWELL);
    applyStimulus(4'h7, P1, DWELL);
    an = 4'hE;
    seg = P4;
    @(posedge clk);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (frame_strobe) break;
      n++;
    end
    checkOutput("strobe latency", 16'(n), 16'(SC));
    @(negedge clk);
    checkOutput("strobe one cycle", {15'h0, frame_strobe}, 16'h0);
    applyStimulus(4'hE, P4, 4);

    // Glitch inside slot 0: a short all-on pattern must never be stored.
    doReset();
    base = strobes;
    sp = seg_pulses;
    applyStimulus(4'hE, P7, 2);
    applyStimulus(4'hE, P8, 3);
    applyStimulus(4'hE, P7, 5);
    applyStimulus(4'hD, P1, DWELL);
    applyStimulus(4'hB, P2, DWELL);
    applyStimulus(4'h7, P3, DWELL);
    applyStimulus(4'hE, P4, DWELL);
    checkOutput("glitch strobe count", 16'(strobes - base), 16'd1);
    checkOutput("glitch seg_error count", 16'(seg_pulses - sp), 16'd0);
    checkFrame("glitch", 16'h3217, 4'b0000, 3'b000);

    // Undecodable segment pattern followed by a multi-anode dwell.
    doReset();
    base = strobes;
    sp = seg_pulses;
    ap = an_pulses;
    applyStimulus(4'hE, P0, DWELL);
    applyStimulus(4'hD, P5, DWELL);
    applyStimulus(4'hB, BAD2, DWELL);
    checkOutput("seg_error pulse", 16'(seg_pulses - sp), 16'd1);
    applyStimulus(4'h7, P9, DWELL);
    applyStimulus(4'hC, P8, DWELL);
    checkOutput("an_error pulse", 16'(an_pulses - ap), 16'd1);
    applyStimulus(4'hE, P0, DWELL);
    checkOutput("err strobe count", 16'(strobes - base), 16'd1);
    checkFrame("err", 16'h9F50, 4'b0100, 3'b011);

    // Scan stops after two slots: timeout closes the frame, then the dark display repeats.
    doReset();
    base = strobes;
    applyStimulus(4'hE, P6, DWELL);
    an = 4'hD;
    seg = P8;
    @(posedge clk);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (strobes != base) break;
      n++;
      if (n == DWELL - 1) begin
        an = 4'hF;
        seg = 7'h7F;
      end
    end
    checkOutput("timeout latency", 16'(n), 16'(SC + TC));
    checkFrame("timeout", 16'hFF86, 4'b1100, 3'b100);
    base = strobes;
    m = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      m++;
      if (strobes != base) break;
    end
    checkOutput("dark timeout period", 16'(m), 16'(TC));
    checkFrame("dark", 16'hFFFF, 4'b1111, 3'b100);

    // Reset in the middle of a frame discards the partial frame.
    doReset();
    applyStimulus(4'hE, P1, DWELL);
    applyStimulus(4'hD, P2, DWELL);
    applyStimulus(4'hB, P3, DWELL);
    applyStimulus(4'h7, P4, DWELL);
    applyStimulus(4'hE, P5, DWELL);
    applyStimulus(4'hD, P6, DWELL);
    checkOutput("pre-reset digits", {digit3, digit2, digit1, digit0}, 16'h4321);
    reset = 1'b1;
    an = 4'hF;
    seg = 7'h7F;
    @(negedge clk);
    checkOutput("midreset digits", {digit3, digit2, digit1, digit0}, 16'hFFFF);
    checkOutput("midreset blank/flags", {9'h0, blank_mask, frame_flags}, {9'h0, 4'b1111, 3'b000});
    reset = 1'b0;
    base = strobes;
    applyStimulus(4'hB, P7, DWELL);
    applyStimulus(4'h7, P8, DWELL);
    applyStimulus(4'hB, P7, DWELL);
    checkOutput("post-reset strobe count", 16'(strobes - base), 16'd1);
    checkFrame("post-reset", 16'h87FF, 4'b0011, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
Receive-side counterpart of the multiplexed 7-segment display driver (seg/an, active-low). It watches the scanned seg/an bus and filters out transition glitches. It decodes each digit slot back to BCD and reassembles complete 4-digit frames, including blanked slots from set-mode blinking. It is used as an on-chip display monitor and readback path, and as a bench checker.

Parameters:
STABLE_CYCLES, 16, consecutive clk cycles {an,seg} must be unchanged before a slot is accepted (legal range 2..65535).
TIMEOUT_CYCLES, 400000, cycles without any accepted slot before a frame is force-closed (4 ms at 100 MHz).

Ports:
clk  input  1  system clock, 100 MHz.
reset  input  1  synchronous, active-high reset.
seg  input  7  segment bus, active-low, seg[6]=g ... seg[0]=a.
an  input  4  anode bus, active-low, an[0] = rightmost digit (digit0).
digit0  output  4  captured digit 0 (BCD, 4'hF = blank/invalid).
digit1  output  4  captured digit 1.
digit2  output  4  captured digit 2.
digit3  output  4  captured digit 3.
blank_mask  output  4  bit i=1: slot i not lit during the frame, or lit with all segments off.
frame_strobe  output  1  1-cycle pulse; digit0..3, blank_mask and frame_flags updated in the same cycle.
frame_flags  output  3  [0] seg_error seen in frame, [1] an_error seen in frame, [2] frame closed by timeout.
seg_error  output  1  1-cycle pulse: accepted slot had an undecodable pattern.
an_error  output  1  1-cycle pulse: stable anode pattern with more than one low bit.

Behaviour:
- Interface: one clock domain, clk. reset is synchronous and active-high.
- Reset values:
  - digit0..3 = 4'hF, blank_mask = 4'b1111, frame_flags = 0.
  - frame_strobe, seg_error and an_error = 0.
  - Internal state: seen mask cleared, working flags cleared, stability counter cleared, idle counter cleared.
  - Previous-sample register = {4'b1111, 7'b1111111}.
  - Reset mid-frame discards the partial frame.
- Stability filter:
  - {an,seg} is registered every cycle.
  - If it equals the previous sample, stab_cnt increments, saturating. Otherwise stab_cnt = 0 and the dwell-accepted flag clears.
  - A dwell is qualified exactly once, in the cycle stab_cnt reaches STABLE_CYCLES-1, if the dwell-accepted flag is clear. The flag is then set.
- Qualified dwell classification:
  - an = 4'b1111: ignored, idle counter keeps running.
  - Exactly one low bit (slot i): the slot is accepted.
  - Two or more low bits: an_error pulses the next cycle, working flag[1] is set, nothing is stored.
- Decode table (seg[6:0] -> value):
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4.
  - 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - 1111111 = blank: value F, slot marked blank, no error.
  - Any other pattern: value F, slot marked blank, seg_error pulse, working flag[0] set.
- Accepting slot i:
  - If seen[i] is already set (wrap), close the current frame first (see frame close).
  - The new slot then opens the next frame: seen = only bit i, working value i stored, working flags = this slot's errors only.
  - If seen[i] is clear: store the value, set seen[i].
- Frame close (publish):
  - Next cycle: digitN = working value, or F for unseen slots.
  - blank_mask = ~seen | decoded-blank slots.
  - frame_flags = working flags.
  - frame_strobe = 1.
  - Latency: the strobe comes 1 cycle after the qualifying cycle, i.e. STABLE_CYCLES cycles after the wrapping slot first appears.
- Timeout:
  - idle_cnt clears on every accepted slot, otherwise increments.
  - When it reaches TIMEOUT_CYCLES-1, the frame closes with flag[2] = 1, even if seen is empty (result: all F, blank_mask 1111).
  - The working state clears and idle_cnt restarts, so a dark display strobes once per TIMEOUT_CYCLES.
  - An acceptance in the same cycle wins; no timeout fires.
- Width rule: the counter widths are $clog2 of the respective parameter; there is no wrap.

Test Plan:
Use STABLE_CYCLES=4 and TIMEOUT_CYCLES=64 throughout.
1. Normal scan. Scan an 1110/1101/1011/0111 with seg for 4,3,2,1, 10 cycles each, two rounds.
   -> frame_strobe 4 cycles into round-2 slot 0; digit3..0 = 1,2,3,4; blank_mask 0000; flags 000.
2. Blink. Same scan with slots 0 and 1 driven an=1111.
   -> digit0/1 = F; blank_mask 0011; flags 000.
3. Glitch. A seg=0000000 glitch of 3 cycles inside a 10-cycle slot showing 7.
   -> glitch never stored; slot value 7; no seg_error.
4. Errors. Slot 2 shows 0101010, then a stable an=1100 dwell.
   -> seg_error pulse, digit2 = F, an_error pulse; next strobe flags = 011.
5. Timeout. Stop the scan (an=1111) after 2 slots.
   -> strobe 64 cycles after the last acceptance; flags = 100; unseen slots F.
6. Reset mid-frame. Assert reset after slot 1.
   -> all outputs at reset values next cycle; the first post-reset frame contains only newly scanned slots.
